// File: rtl/vx_tensor_wb_pkg.sv
// VX_tensor_pkg: shared tile, writeback-entry and drain-state types for the tensor result path
package VX_tensor_pkg;
  localparam int TILE_DIM = 4;
  localparam int NW_WIDTH = 4;
  typedef logic [TILE_DIM-1:0][31:0] tile_row_t;
  typedef tile_row_t [TILE_DIM-1:0] tile_t;
  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    tile_t               tile;
  } wb_entry_t;
  typedef enum logic {WB_IDLE, WB_SEND} wb_state_t;
endpackage

// File: rtl/vx_tensor_wb_fifo.sv
// VX_fifo_queue: power-of-two circular buffer whose head is read straight from flop storage
module VX_fifo_queue #(
  parameter int DATAW = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATAW-1:0]           data_in,
  output logic [DATAW-1:0]           data_out,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     size
);
  localparam int AW = $clog2(DEPTH);
  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic wr_en;
  assign full = size == (AW+1)'(DEPTH);
  assign wr_en = push && !full;
  assign data_out = mem[rd_ptr];
  // pointers and occupancy wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      size <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(pop);
      size <= size + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end
  // storage needs no reset; a stale slot is never read while the queue is empty
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/vx_tensor_wb.sv
// vx_tensor_wb: buffers DPU result tiles and drains them one row per handshake to writeback
module vx_tensor_wb
  import VX_tensor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  tile_t               D_tile,
  input  logic [NW_WIDTH-1:0] D_wid,
  output logic                stall,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [NW_WIDTH-1:0] wb_wid,
  output logic [1:0]          wb_row,
  output tile_row_t           wb_data,
  output logic                wb_last,
  output logic [31:0]         tiles_done
);
  localparam int AW = $clog2(DEPTH);
  wb_state_t state, state_n;
  wb_entry_t head;
  logic [AW:0] size;
  logic [1:0] row_cnt;
  logic full, push, fire, pop;
  assign stall = full;
  assign push = valid_in && !full;
  assign fire = wb_valid && wb_ready;
  assign pop = fire && row_cnt == 2'd3;
  assign wb_valid = state == WB_SEND;
  assign wb_row = row_cnt;
  assign wb_last = wb_valid && row_cnt == 2'd3;
  assign wb_wid = wb_valid ? head.wid : '0;
  assign wb_data = wb_valid ? head.tile[row_cnt] : '0;
  VX_fifo_queue #(.DATAW($bits(wb_entry_t)), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .data_in({D_wid, D_tile}),
    .data_out(head),
    .full(full),
    .size(size)
  );
  // enter SEND on the capture edge so row 0 appears the cycle after capture
  always_comb begin
    state_n = (state == WB_IDLE) ? (push ? WB_SEND : WB_IDLE)
            : ((pop && size == (AW+1)'(1) && !push) ? WB_IDLE : WB_SEND);
  end
  // drain state, row position and drained-tile counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= WB_IDLE;
      row_cnt <= '0;
      tiles_done <= '0;
    end else begin
      state <= state_n;
      row_cnt <= row_cnt + 2'(fire);
      tiles_done <= tiles_done + 32'(pop);
    end
  end
endmodule

// File: tb/tb_vx_tensor_wb.sv
// tb_vx_tensor_wb: directed scoreboard bench for the tensor writeback receiver
module tb_vx_tensor_wb;
  import VX_tensor_pkg::*;
  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    logic [1:0]          row;
    tile_row_t           data;
    logic                last;
  } exp_t;
  logic clk = 0;
  logic reset, valid_in, wb_ready;
  tile_t D_tile;
  logic [NW_WIDTH-1:0] D_wid;
  logic stall, wb_valid, wb_last;
  logic [NW_WIDTH-1:0] wb_wid;
  logic [1:0] wb_row;
  tile_row_t wb_data;
  logic [31:0] tiles_done;
  exp_t sb [$];
  int checks = 0;
  int passed = 0;
  vx_tensor_wb #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .D_tile(D_tile), .D_wid(D_wid),
    .stall(stall), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid),
    .wb_row(wb_row), .wb_data(wb_data), .wb_last(wb_last), .tiles_done(tiles_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic tile_t mk(input int base);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = 32'(base + 16*r + c);
    return t;
  endfunction
  task automatic present(input int wid, input int base);
    exp_t e;
    tile_t t;
    t = mk(base);
    valid_in = 1;
    D_wid = NW_WIDTH'(wid);
    D_tile = t;
    for (int r = 0; r < 4; r++) begin
      e.wid = NW_WIDTH'(wid);
      e.row = 2'(r);
      e.data = t[r];
      e.last = (r == 3);
      sb.push_back(e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || wb_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 160'(sb.size()), 160'(0));
  endtask
  task automatic wait_row(input logic [1:0] r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb_row != r && n < 40);
    chk("wait_row", 160'(wb_row), 160'(r));
  endtask
  // scoreboard: every accepted row must be the next expected one
  always @(negedge clk) begin
    if (reset === 1'b1 && wb_valid && wb_ready) begin
      if (sb.size() == 0) chk("extra_row", 160'(sb.size()), 160'(1));
      else chk("row", 160'({wb_wid, wb_row, wb_data, wb_last}), 160'(sb.pop_front()));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [127:0] r1;
    tile_t t;
    r1 = {32'd19, 32'd18, 32'd17, 32'd16};
    reset = 0; valid_in = 0; wb_ready = 0; D_tile = '0; D_wid = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_stall", 160'(stall), 160'(0));
    chk("rst_valid", 160'(wb_valid), 160'(0));
    chk("rst_row", 160'(wb_row), 160'(0));
    chk("rst_last", 160'(wb_last), 160'(0));
    chk("rst_wid", 160'(wb_wid), 160'(0));
    chk("rst_data", 160'(wb_data), 160'(0));
    chk("rst_done", 160'(tiles_done), 160'(0));
    step();
    reset = 1;
    step();
    wb_ready = 1;
    present(2, 0);
    step();
    valid_in = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_valid", 160'(wb_valid), 160'(1));
      chk("single_row", 160'(wb_row), 160'(i));
      chk("single_last", 160'(wb_last), 160'(i == 3));
      if (i == 1) chk("single_row1_data", 160'(wb_data), 160'(r1));
    end
    @(negedge clk);
    chk("single_idle", 160'(wb_valid), 160'(0));
    chk("single_done", 160'(tiles_done), 160'(1));
    step();
    wb_ready = 0;
    present(1, 256);
    step();
    valid_in = 0;
    t = mk(256);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 160'(wb_valid), 160'(1));
      chk("bp_row", 160'(wb_row), 160'(0));
      chk("bp_data", 160'(wb_data), 160'(t[0]));
    end
    step();
    wb_ready = 1;
    wait_drain();
    chk("bp_done", 160'(tiles_done), 160'(2));
    step();
    wb_ready = 0;
    for (int w = 0; w < 4; w++) begin
      present(w, 4096 * (w + 1));
      step();
    end
    present(4, 4096 * 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_stall", 160'(stall), 160'(1));
      chk("full_head_wid", 160'(wb_wid), 160'(0));
    end
    step();
    wb_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pop_stall", 160'(stall), 160'(1));
    end
    @(negedge clk);
    chk("after_pop_stall", 160'(stall), 160'(0));
    step();
    valid_in = 0;
    @(negedge clk);
    chk("refill_stall", 160'(stall), 160'(1));
    wait_drain();
    chk("fill_done", 160'(tiles_done), 160'(7));
    repeat (3) begin
      @(negedge clk);
      chk("no_dup", 160'(wb_valid), 160'(0));
    end
    step();
    present(5, 20480);
    step();
    valid_in = 0;
    wait_row(2);
    #1;
    reset = 0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", 160'(wb_valid), 160'(0));
    chk("mid_rst_stall", 160'(stall), 160'(0));
    chk("mid_rst_done", 160'(tiles_done), 160'(0));
    step();
    reset = 1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", 160'(wb_valid), 160'(0));
    end
    step();
    force dut.tiles_done = 32'hFFFF_FFFF;
    present(6, 24576);
    step();
    valid_in = 0;
    wait_row(3);
    #1;
    release dut.tiles_done;
    @(negedge clk);
    chk("wrap_done", 160'(tiles_done), 160'(0));
    wait_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vx_tensor_wb.md
# VX_tensor_wb

Result-side receiver for the tensor dot-product unit. Accepts completed 4x4 FP32 D tiles from the tensor DPU's fixed-latency output, buffers them, and drains each tile to the register-file writeback port one row per handshake. When its buffer fills, it drives `stall` back to the DPU, freezing the DPU shift register until space frees. It sits between the tensor DPU and the warp writeback arbiter.

## Interface
- `DEPTH`, 4: tile buffer entries; power of two, >= 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low; asserted when 0.
- `valid_in`  in  1  DPU result valid; held while `stall` = 1.
- `D_tile`  in  [3:0][3:0][31:0]  result tile; indices are [row][col].
- `D_wid`  in  `NW_WIDTH`  warp id of the tile.
- `stall`  out  1  freeze request to the DPU pipeline.
- `wb_valid`  out  1  a writeback row is presented.
- `wb_ready`  in  1  arbiter accepts the row.
- `wb_wid`  out  `NW_WIDTH`  warp id of the current row.
- `wb_row`  out  2  row index, 0..3.
- `wb_data`  out  [3:0][31:0]  the four column values of the row.
- `wb_last`  out  1  current row is row 3.
- `tiles_done`  out  32  count of fully drained tiles; wraps.

## Operation
- Push: a tile is captured when `valid_in && !stall`. The FIFO stores {wid, tile}. Nothing is captured while `stall` = 1, because the DPU re-presents the same tile on every frozen cycle.
- `stall` = (count == DEPTH). It is derived from registered state only, with no combinational path from `wb_ready`.
- Drain: the head entry is presented row by row. `wb_data` = head.tile[row_cnt], `wb_row` = row_cnt, and `wb_last` = (row_cnt == 3).
  - On `wb_valid && wb_ready`, row_cnt increments.
  - At row 3 the handshake pops the entry, row_cnt wraps to 0, and `tiles_done` increments.
- Drain state machine:
  - IDLE: FIFO empty, `wb_valid` = 0. Moves to SEND when count becomes nonzero.
  - SEND: `wb_valid` = 1. Leaves after the row-3 handshake; goes to IDLE if the FIFO becomes empty, otherwise stays in SEND on the next entry.
- Stability: once `wb_valid` is asserted, `wb_wid`, `wb_row` and `wb_data` are held stable until the handshake.
- Simultaneous push and pop:
  - When count < DEPTH, both occur and count is unchanged.
  - When full, the pop occurs but the push does not, since `stall` was 1. The tile is taken on the following cycle.
- Count and pointers: wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Reset: when `reset` = 0, the FIFO is emptied, row_cnt = 0, state = IDLE and `tiles_done` = 0. Buffered tiles are discarded; rows already written back are not retracted.

## Timing
- Reset values: `stall` = 0, `wb_valid` = 0, `wb_row` = 0, `wb_last` = 0, `wb_wid` = 0, `wb_data` = 0, `tiles_done` = 0.
- Latency: a tile pushed at edge t is presented as row 0 at t+1, so `wb_valid` is high in the cycle after capture. There is no bypass.
- Throughput: with `wb_ready` held at 1, one tile drains every 4 cycles. The DPU can deliver one tile per cycle, so `stall` asserts after DEPTH tiles arrive back-to-back faster than the drain rate.
- `stall` updates the cycle after count reaches DEPTH and deasserts the cycle after a pop.
- `tiles_done` updates the cycle after the row-3 handshake.

## Structure
- Shared package `VX_tensor_pkg`:
  - `TILE_DIM` = 4.
  - `tile_row_t` = [3:0][31:0].
  - `tile_t` = [3:0] `tile_row_t`.
  - `wb_entry_t` = {wid, `tile_t`}.
- One sub-module: the codebase `VX_fifo_queue`, with DATAW = `$bits(wb_entry_t)` and DEPTH = `DEPTH`, using registered output.
- Top level holds the drain FSM, row_cnt, stall logic and `tiles_done`.

## Test plan
- Single tile: send one tile with wid=2 and D[r][c] = 16r+c, `wb_ready` = 1.
  - Expect rows 0..3 on 4 consecutive cycles starting the cycle after capture.
  - Expect `wb_data` row 1 = {19,18,17,16} in [3:0] order, with `wb_last` only on row 3.
  - Expect `tiles_done` = 1.
- Backpressure on drain: hold `wb_ready` = 0 for 5 cycles while a tile is buffered.
  - Expect `wb_valid` = 1, `wb_row` = 0 and `wb_data` stable throughout.
  - After release, expect the 4 rows in order.
- Fill to full: DEPTH = 4, `wb_ready` = 0, present 5 tiles back-to-back (wids 0..4).
  - Expect `stall` = 1 after the 4th capture.
  - Expect tile 4 held and not captured while stalled.
  - After one full drain, expect tile 4 captured exactly once; the drain order is wids 0,1,2,3,4.
- Simultaneous push/pop at full: on the row-3 handshake with `valid_in` = 1, expect no capture that cycle, capture on the next cycle, and count back to DEPTH.
- Reset mid-drain: assert `reset` = 0 during row 2 of a tile.
  - Expect `wb_valid` = 0, `stall` = 0 and `tiles_done` = 0 on the next cycle.
  - Expect no stale rows to reappear after reset is released.
- Counter wrap: preload `tiles_done` by forcing it to 32'hFFFF_FFFF, then drain one tile; expect 0.
